// File: rtl/drac_pkg.sv
// Shared types for the DRAC pipeline hazard controller.
//   next_pc_sel_t : fetch next-PC source (PC, PC+4, jump target, trap vector)
//   sel_addr_if_t : jump target source (decode-stage JAL or commit-stage branch)
//   hz_state_t    : exception redirect FSM states
package drac_pkg;

    typedef enum logic [1:0] {
        NEXT_PC_SEL_PC   = 2'd0,
        NEXT_PC_SEL_PC_4 = 2'd1,
        NEXT_PC_SEL_JUMP = 2'd2,
        NEXT_PC_SEL_TRAP = 2'd3
    } next_pc_sel_t;

    typedef enum logic {
        SEL_JUMP_DECODE = 1'b0,
        SEL_JUMP_COMMIT = 1'b1
    } sel_addr_if_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_DRAIN    = 2'd1,
        HZ_REDIRECT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register.
// Ports:
//   clk_i, rst_i            clock, async active-high reset (all bits cleared)
//   set_i / set_addr_i      mark a register as having an in-flight write
//   clr_i / clr_addr_i      write-back retires the pending write
//   clr_all_i               drop every pending bit (pipeline flush)
//   rd1/rd2_addr_i, rd1/rd2_o  combinational read ports
// Set beats clear on the same register; register 0 is never marked.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic                  clr_all_i,
    input  logic [REG_ADDR_W-1:0] rd1_addr_i,
    output logic                  rd1_o,
    input  logic [REG_ADDR_W-1:0] rd2_addr_i,
    output logic                  rd2_o
);

    logic [NUM_REGS-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_all_i) begin
            sb_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (clr_i && clr_addr_i == REG_ADDR_W'(i)) sb_d[i] = 1'b0;
                if (set_i && set_addr_i == REG_ADDR_W'(i) && i != 0) sb_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd1_o = 1'b0;
        rd2_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd1_addr_i == REG_ADDR_W'(i)) rd1_o = sb_q[i];
            if (rd2_addr_i == REG_ADDR_W'(i)) rd2_o = sb_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sb_q <= '0;
        else       sb_q <= sb_d;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control unit for the in-order DRAC core.
// Produces per-stage stall/flush vectors, next-PC select and jump source select,
// with RAW interlocks via a register scoreboard, multi-cycle EXE back-pressure and
// an exception FSM (RUN -> DRAIN -> REDIRECT) that waits for memory to go idle
// before steering fetch to the trap vector.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   valid_fetch_i                IF holds a valid instruction
//   id_*                         ID instruction: sources, destination, JAL flag
//   exe_busy_i                   multi-cycle EXE unit still working
//   wb_*                         WB status: write-back, branch resolution, exception
//   mem_pending_i                outstanding data-memory access
//   next_pc_sel_o, sel_addr_if_o fetch steering
//   stall_o, flush_o             per-stage hold / bubble (flush overrides stall)
//   busy_o                       exception sequence in progress
// Optional: define PIPE_HAZARD_PERF_EN to add saturating perf counters
//   perf_raw_stall_o, perf_exe_stall_o, perf_flush_o.
module pipeline_hazard_ctrl
    import drac_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          WB_BYPASS  = 1'b1
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_CNT_W = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_fetch_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_rd_we_i,
    input  logic                  id_jal_i,
    input  logic                  exe_busy_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_rd_we_i,
    input  logic                  wb_change_pc_i,
    input  logic                  wb_branch_taken_i,
    input  logic                  wb_xcpt_i,
    input  logic                  mem_pending_i,
    output next_pc_sel_t          next_pc_sel_o,
    output sel_addr_if_t          sel_addr_if_o,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  busy_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_raw_stall_o,
    output logic [PERF_CNT_W-1:0] perf_exe_stall_o,
    output logic [PERF_CNT_W-1:0] perf_flush_o
`endif
);

    hz_state_t state_q, state_d;

    logic trap, redirect_br, wb_wr, raw1, raw2, raw;
    logic rs1_pend, rs2_pend;
    logic sb_set, sb_clr_all;
    logic raw_taken, exe_taken, redirect_evt;

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (sb_set),
        .set_addr_i(id_rd_i),
        .clr_i     (wb_wr),
        .clr_addr_i(wb_rd_i),
        .clr_all_i (sb_clr_all),
        .rd1_addr_i(id_rs1_i),
        .rd1_o     (rs1_pend),
        .rd2_addr_i(id_rs2_i),
        .rd2_o     (rs2_pend)
    );

    always_comb begin
        trap        = wb_valid_i & wb_xcpt_i;
        redirect_br = wb_valid_i & wb_change_pc_i & wb_branch_taken_i & ~wb_xcpt_i;
        wb_wr       = wb_valid_i & wb_rd_we_i;
        // A result being written back this cycle is forwarded, so no interlock.
        raw1 = id_rs1_used_i && (id_rs1_i != '0) && rs1_pend &&
               !(WB_BYPASS && wb_wr && (wb_rd_i == id_rs1_i));
        raw2 = id_rs2_used_i && (id_rs2_i != '0) && rs2_pend &&
               !(WB_BYPASS && wb_wr && (wb_rd_i == id_rs2_i));
        raw  = raw1 | raw2;
    end

    always_comb begin
        state_d       = state_q;
        stall_o       = '0;
        flush_o       = '0;
        next_pc_sel_o = NEXT_PC_SEL_PC;
        sel_addr_if_o = SEL_JUMP_COMMIT;
        busy_o        = (state_q != HZ_RUN);
        sb_set        = 1'b0;
        sb_clr_all    = 1'b0;
        raw_taken     = 1'b0;
        exe_taken     = 1'b0;
        redirect_evt  = 1'b0;

        unique case (state_q)
            HZ_RUN: begin
                if (trap) begin
                    flush_o[NUM_STAGES-2:0] = '1;
                    sb_clr_all              = 1'b1;
                    redirect_evt            = 1'b1;
                    state_d                 = HZ_DRAIN;
                end else if (redirect_br) begin
                    flush_o[NUM_STAGES-2:0] = '1;
                    sb_clr_all              = 1'b1;
                    redirect_evt            = 1'b1;
                    next_pc_sel_o           = NEXT_PC_SEL_JUMP;
                end else if (exe_busy_i) begin
                    stall_o[NUM_STAGES-2:0] = '1;
                    flush_o[NUM_STAGES-1]   = 1'b1;
                    exe_taken               = 1'b1;
                end else if (raw) begin
                    stall_o[1:0] = 2'b11;
                    flush_o[2]   = 1'b1;
                    raw_taken    = 1'b1;
                end else begin
                    // ID instruction advances: record its destination as pending.
                    sb_set = id_valid_i & id_rd_we_i & (id_rd_i != '0);
                    if (id_valid_i && id_jal_i) begin
                        flush_o[0]    = 1'b1;
                        next_pc_sel_o = NEXT_PC_SEL_JUMP;
                        sel_addr_if_o = SEL_JUMP_DECODE;
                        redirect_evt  = 1'b1;
                    end else begin
                        next_pc_sel_o = valid_fetch_i ? NEXT_PC_SEL_PC_4 : NEXT_PC_SEL_PC;
                    end
                end
            end
            HZ_DRAIN: begin
                // Hold fetch, keep bubbles flowing until memory goes idle.
                stall_o[0]              = 1'b1;
                flush_o[NUM_STAGES-1:1] = '1;
                if (!mem_pending_i) state_d = HZ_REDIRECT;
            end
            HZ_REDIRECT: begin
                next_pc_sel_o           = NEXT_PC_SEL_TRAP;
                flush_o[NUM_STAGES-1:1] = '1;
                state_d                 = HZ_RUN;
            end
            default: state_d = HZ_RUN;
        endcase

        if (rst_i) begin
            stall_o       = '0;
            flush_o       = '1;
            next_pc_sel_o = NEXT_PC_SEL_PC;
            sel_addr_if_o = SEL_JUMP_COMMIT;
            busy_o        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= HZ_RUN;
        else       state_q <= state_d;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] raw_cnt_q, exe_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_cnt_q   <= '0;
            exe_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (raw_taken && raw_cnt_q != '1)      raw_cnt_q   <= raw_cnt_q + 1'b1;
            if (exe_taken && exe_cnt_q != '1)      exe_cnt_q   <= exe_cnt_q + 1'b1;
            if (redirect_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign perf_raw_stall_o = raw_cnt_q;
    assign perf_exe_stall_o = exe_cnt_q;
    assign perf_flush_o     = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = raw_taken ^ exe_taken ^ redirect_evt;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised next-generation pipeline control unit for the in-order DRAC core.
- Generates per-stage stall/flush vectors, fetch next-PC select and jump-source select.
- Adds a register scoreboard for RAW interlocks, multi-cycle EXE back-pressure, and an exception redirect FSM that drains outstanding memory operations before trapping.
- Sits beside the datapath; consumes ID, EXE and WB status, drives every pipeline register.

Parameters:
- NUM_STAGES, 5, pipeline stages. Index 0=IF, 1=ID, 2=RR, NUM_STAGES-2=EXE, NUM_STAGES-1=WB. Legal range 4..8.
- NUM_REGS, 32, architectural integer registers tracked.
- REG_ADDR_W, 5, register index width; NUM_REGS <= 2**REG_ADDR_W.
- WB_BYPASS, 1, when 1 a same-cycle WB write to a source register does not cause a RAW stall.
- PERF_CNT_W, 32, perf counter width (optional feature only).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_fetch_i  in  1  IF holds a valid fetched instruction.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs1_i / id_rs2_i  in  REG_ADDR_W  ID source registers.
- id_rs1_used_i / id_rs2_used_i  in  1  source register is actually read.
- id_rd_i  in  REG_ADDR_W  ID destination register.
- id_rd_we_i  in  1  ID instruction writes rd.
- id_jal_i  in  1  ID holds a JAL.
- exe_busy_i  in  1  multi-cycle EXE unit not finished.
- wb_valid_i  in  1  WB holds a valid instruction.
- wb_rd_i  in  REG_ADDR_W  WB destination.
- wb_rd_we_i  in  1  WB writes rd this cycle.
- wb_change_pc_i / wb_branch_taken_i  in  1  resolved control-flow change at WB.
- wb_xcpt_i  in  1  WB instruction raises an exception.
- mem_pending_i  in  1  outstanding data-memory transaction.
- next_pc_sel_o  out  2  next_pc_sel_t: PC, PC_4, JUMP, TRAP.
- sel_addr_if_o  out  1  sel_addr_if_t: JUMP_DECODE, JUMP_COMMIT.
- stall_o  out  NUM_STAGES  bit k: stage k register holds.
- flush_o  out  NUM_STAGES  bit k: stage k register loads a bubble at next edge (overrides stall).
- busy_o  out  1  FSM not in RUN.

Behaviour:
- Reset (rst_i high, async): FSM=RUN, scoreboard all 0. Outputs while rst_i high: stall_o=0, flush_o=all 1, next_pc_sel_o=PC, sel_addr_if_o=JUMP_COMMIT, busy_o=0.
- Control signals:
  - redirect_br = wb_valid_i & wb_change_pc_i & wb_branch_taken_i & !wb_xcpt_i.
  - trap = wb_valid_i & wb_xcpt_i.
- RAW condition: for each used source s != 0 with scoreboard[s]=1, a stall is required. When WB_BYPASS=1, no stall if wb_valid_i & wb_rd_we_i & wb_rd_i==s.
- Priority, highest first:
  1. trap (RUN only): flush_o[0..NUM_STAGES-2]=1, stall_o=0, next_pc_sel_o=PC, scoreboard cleared. Next state DRAIN.
  2. redirect_br (RUN only): same flush, scoreboard cleared, next_pc_sel_o=JUMP, sel_addr_if_o=JUMP_COMMIT.
  3. exe_busy_i: stall_o[0..NUM_STAGES-2]=1, flush_o[NUM_STAGES-1]=1.
  4. raw: stall_o[0..1]=1, flush_o[2]=1.
  5. id_valid_i & id_jal_i: flush_o[0]=1, next_pc_sel_o=JUMP, sel_addr_if_o=JUMP_DECODE. A JAL held in ID by exe_busy_i does not redirect until it advances.
  6. Otherwise next_pc_sel_o = valid_fetch_i ? PC_4 : PC.
- Scoreboard updates:
  - Set bit id_rd_i on issue: id_valid_i & id_rd_we_i & id_rd_i!=0, with no trap, redirect_br, exe_busy_i or raw, and state RUN.
  - Clear bit wb_rd_i when wb_valid_i & wb_rd_we_i.
  - Same-register set and clear in the same cycle: set wins.
  - Bit 0 is never set.
- FSM:
  - RUN -> DRAIN on trap.
  - DRAIN: stall_o[0]=1, flush_o[1..NUM_STAGES-1]=1, next_pc_sel_o=PC, all other inputs ignored. Exit to REDIRECT when mem_pending_i=0.
  - REDIRECT, one cycle: next_pc_sel_o=TRAP, flush_o[1..NUM_STAGES-1]=1, stall_o=0. Then RUN.
  - Minimum trap-to-TRAP latency is 2 cycles.
- A trap arriving in DRAIN or REDIRECT is ignored; only bubbles are in flight.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_raw_stall_o, perf_exe_stall_o and perf_flush_o, each PERF_CNT_W wide.
  - They count cycles with a raw stall (priority 4 taken), cycles with exe_busy_i stall, and redirect events (trap, branch or JAL).
  - Counters reset to 0 and saturate at all-ones.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- drac_pkg holds next_pc_sel_t {NEXT_PC_SEL_PC, NEXT_PC_SEL_PC_4, NEXT_PC_SEL_JUMP, NEXT_PC_SEL_TRAP}, sel_addr_if_t, and the hazard FSM state enum {HZ_RUN, HZ_DRAIN, HZ_REDIRECT}.
- Sub-module reg_scoreboard: set/clear ports, two combinational read ports, async-reset flop array, clear-all input.

Test Plan:
- Issue ADDI x5 (rd_we) then ADD reading x5 next cycle, WB 3 cycles later -> stall_o[1:0]=11 and flush_o[2]=1 until WB cycle. With WB_BYPASS=1 the stall drops in the WB cycle; scoreboard[5] returns to 0.
- exe_busy_i high 4 cycles, NUM_STAGES=5 -> stall_o=01111, flush_o=10000 for exactly 4 cycles; a JAL in ID redirects only on the cycle after exe_busy_i falls.
- Branch taken at WB together with raw and id_jal_i -> flush_o=01111, next_pc_sel_o=JUMP, sel_addr_if_o=JUMP_COMMIT, scoreboard all 0 next cycle.
- wb_xcpt_i with mem_pending_i high 3 cycles -> busy_o=1, 3 DRAIN cycles with next_pc_sel_o=PC, then one cycle TRAP, then RUN.
- Same-cycle issue of rd=x7 and WB write of x7 -> scoreboard[7]=1 afterwards; issue with rd=x0 -> no bit set.
- Assert rst_i mid-DRAIN -> immediate flush_o=all 1, next_pc_sel_o=PC, busy_o=0, and state RUN after release.
